// File: rtl/uart_tx_path.sv
// UART transmit path: a circular FIFO feeding an LSB-first serializer paced by
// a 16x baud-rate oversampling strobe.
module uart_tx_path #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  output logic            full,
  output logic            empty,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int DEPTH = 1 << FIFO_W;
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0] w_ptr, r_ptr, w_ptr_succ, r_ptr_succ;
  logic              push, pop;

  state_t          state_reg, state_next;
  logic [3:0]      s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;

  assign w_ptr_succ = w_ptr + FIFO_W'(1);
  assign r_ptr_succ = r_ptr + FIFO_W'(1);
  assign push       = wr & ~full;

  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[w_ptr] <= w_data;
  end

  // A simultaneous push and pop moves both pointers and leaves the count, and
  // therefore both flags, untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) begin
        w_ptr <= w_ptr_succ;
        if (!pop) begin
          empty <= 1'b0;
          full  <= (w_ptr_succ == r_ptr);
        end
      end
      if (pop) begin
        r_ptr <= r_ptr_succ;
        if (!push) begin
          full  <= 1'b0;
          empty <= (r_ptr_succ == w_ptr);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
    end
  end

  // tx is registered, so it is loaded with the level of the bit being entered
  // on each state/bit transition to keep every bit exactly 16 ticks wide.
  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    b_next       = b_reg;
    tx_next      = tx_reg;
    pop          = 1'b0;
    tx_done_tick = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          b_next     = mem[r_ptr];
          s_next     = '0;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == 4'd15) begin
            s_next     = '0;
            n_next     = '0;
            tx_next    = b_reg[0];
            state_next = DATA;
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == 4'd15) begin
            s_next = '0;
            b_next = b_reg >> 1;
            n_next = n_reg + NW'(1);
            if (n_reg == N_LAST) begin
              tx_next    = 1'b1;
              state_next = STOP;
            end else begin
              tx_next = b_next[0];
            end
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP) begin
            tx_done_tick = 1'b1;
            state_next   = IDLE;
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_path.sv
// Directed bench for uart_tx_path: frame shape, FIFO full/empty behaviour,
// back-to-back frames, slow baud strobe and mid-frame reset.
module tb_uart_tx_path;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       wr;
  logic [7:0] w_data;
  logic       full, empty, tx, tx_busy, tx_done_tick;

  int checks = 0;
  int errors = 0;
  int tick_div = 0;
  int div_cnt = 0;

  uart_tx_path #(.DBIT(8), .SB_TICK(16), .FIFO_W(4)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .wr(wr), .w_data(w_data),
    .full(full), .empty(empty), .tx(tx), .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; s_tick for the next cycle is set just after the edge and
  // outputs are observed once combinational logic has settled.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (tick_div == 0) s_tick = 1'b0;
    else if (div_cnt >= tick_div - 1) begin
      s_tick  = 1'b1;
      div_cnt = 0;
    end else begin
      s_tick = 1'b0;
      div_cnt++;
    end
    #1;
  endtask

  // Observation index at which frame bit k begins, for first tick in the cycle
  // after observation a and a tick every p cycles; k == 10 is the frame end.
  function automatic int bit_start(input int k, input int a, input int p);
    if (k == 0) return 0;
    return a + (16 * k - 1) * p + 1;
  endfunction

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    return 1'b1;
  endfunction

  // Called at observation 0 of a frame (first cycle with tx low).
  task automatic frame_check(input string tag, input logic [7:0] d, input int a, input int p);
    int len, k, bad_tx, bad_busy, n_done, done_at;
    logic [7:0] rx;
    len = bit_start(10, a, p);
    k = 0; bad_tx = 0; bad_busy = 0; n_done = 0; done_at = -1; rx = '0;
    for (int i = 0; i < len; i++) begin
      if (k < 9 && i == bit_start(k + 1, a, p)) k++;
      if (tx !== exp_bit(d, k)) bad_tx++;
      if (tx_busy !== 1'b1) bad_busy++;
      if (tx_done_tick === 1'b1) begin
        n_done++;
        done_at = i;
      end
      if (k >= 1 && k <= 8 && i == bit_start(k, a, p) + 8 * p) rx[k-1] = tx;
      cyc();
    end
    chkn({tag, ".tx_bad_cycles"}, bad_tx, 0);
    chkn({tag, ".busy_bad_cycles"}, bad_busy, 0);
    chkn({tag, ".rx_byte"}, int'(rx), int'(d));
    chkn({tag, ".done_count"}, n_done, 1);
    chkn({tag, ".done_index"}, done_at, len - 1);
    chk1({tag, ".end_busy"}, tx_busy, 1'b0);
    chk1({tag, ".end_tx"}, tx, 1'b1);
    chk1({tag, ".end_done"}, tx_done_tick, 1'b0);
  endtask

  task automatic wait_start(input string tag, input int maxc, input int exp_wait);
    int w;
    w = 0;
    while (tx !== 1'b0 && w < maxc) begin
      cyc();
      w++;
    end
    chkn(tag, w, exp_wait);
  endtask

  initial begin
    int lows, dones;

    // Reset values
    reset = 1'b1; wr = 1'b0; s_tick = 1'b0; w_data = '0;
    repeat (3) cyc();
    reset = 1'b0;
    chk1("rst.tx", tx, 1'b1);
    chk1("rst.busy", tx_busy, 1'b0);
    chk1("rst.empty", empty, 1'b1);
    chk1("rst.full", full, 1'b0);
    chk1("rst.done", tx_done_tick, 1'b0);

    // 0xA5 with s_tick every cycle
    tick_div = 1; div_cnt = 0; s_tick = 1'b1;
    repeat (5) cyc();
    chk1("idle.tx", tx, 1'b1);
    w_data = 8'hA5; wr = 1'b1;
    cyc();
    wr = 1'b0;
    chk1("a5.empty_after_wr", empty, 1'b0);
    chk1("a5.tx_after_wr", tx, 1'b1);
    cyc();
    chk1("a5.latency_tx_low", tx, 1'b0);
    frame_check("a5", 8'hA5, 0, 1);
    chk1("a5.empty_after", empty, 1'b1);
    repeat (20) cyc();
    chk1("a5.empty_later", empty, 1'b1);
    chk1("a5.tx_later", tx, 1'b1);

    // Stalled strobe: 0xC3 is held in START while the FIFO is filled
    tick_div = 0; s_tick = 1'b0;
    w_data = 8'hC3; wr = 1'b1;
    cyc();
    wr = 1'b0;
    cyc();
    chk1("fill.c3_started", tx, 1'b0);
    chk1("fill.c3_popped", empty, 1'b1);
    for (int j = 0; j < 16; j++) begin
      w_data = 8'(j); wr = 1'b1;
      cyc();
      if (j == 14) chk1("fill.full_after_15", full, 1'b0);
    end
    chk1("fill.full_after_16", full, 1'b1);
    chk1("fill.empty_after_16", empty, 1'b0);
    w_data = 8'hFF; wr = 1'b1;
    cyc();
    wr = 1'b0;
    chk1("fill.full_after_17", full, 1'b1);
    chk1("fill.tx_held", tx, 1'b0);
    tick_div = 1; div_cnt = 0; s_tick = 1'b1;
    frame_check("fill.c3", 8'hC3, 0, 1);
    for (int j = 0; j < 16; j++) begin
      wait_start("fill.gap", 5, 1);
      if (j == 0) chk1("fill.full_after_pop", full, 1'b0);
      frame_check($sformatf("fill.b%0d", j), 8'(j), 0, 1);
    end
    chk1("fill.empty_end", empty, 1'b1);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx !== 1'b1) lows++;
      cyc();
    end
    chkn("fill.ff_dropped", lows, 0);

    // 0x55 then 0x0F on consecutive cycles: second write coincides with a pop
    w_data = 8'h55; wr = 1'b1;
    cyc();
    w_data = 8'h0F;
    cyc();
    wr = 1'b0;
    chk1("b2b.tx_low", tx, 1'b0);
    chk1("b2b.empty_one_word", empty, 1'b0);
    chk1("b2b.full", full, 1'b0);
    frame_check("b2b.55", 8'h55, 0, 1);
    chk1("b2b.empty_between", empty, 1'b0);
    wait_start("b2b.gap", 5, 1);
    chk1("b2b.empty_second", empty, 1'b1);
    frame_check("b2b.0f", 8'h0F, 0, 1);

    // Reset during DATA bit 3 of 0x96, with 0x3A still queued
    w_data = 8'h96; wr = 1'b1;
    cyc();
    w_data = 8'h3A;
    cyc();
    wr = 1'b0;
    chk1("rmid.tx_low", tx, 1'b0);
    repeat (70) cyc();
    chk1("rmid.bit3", tx, 1'b0);
    chk1("rmid.busy", tx_busy, 1'b1);
    chk1("rmid.queued", empty, 1'b0);
    reset = 1'b1; w_data = 8'h77; wr = 1'b1;
    cyc();
    chk1("rmid.tx", tx, 1'b1);
    chk1("rmid.busy_after", tx_busy, 1'b0);
    chk1("rmid.empty", empty, 1'b1);
    chk1("rmid.full", full, 1'b0);
    chk1("rmid.done", tx_done_tick, 1'b0);
    reset = 1'b0; wr = 1'b0;
    lows = 0; dones = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx !== 1'b1) lows++;
      if (tx_done_tick !== 1'b0) dones++;
      cyc();
    end
    chkn("rmid.no_frame", lows, 0);
    chkn("rmid.no_done", dones, 0);
    chk1("rmid.empty_later", empty, 1'b1);

    // 0x3C with s_tick every 326 cycles; first tick lands after observation 324
    tick_div = 326; div_cnt = 0; s_tick = 1'b0;
    w_data = 8'h3C; wr = 1'b1;
    cyc();
    wr = 1'b0;
    cyc();
    chk1("slow.tx_low", tx, 1'b0);
    frame_check("slow", 8'h3C, 324, 326);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_path.md
UART_TX_PATH -- requirements
Module: uart_tx_path

Interface
REQ-001 The module SHALL have parameter DBIT, default 8, number of data bits per frame.
REQ-002 The module SHALL have parameter SB_TICK, default 16, number of s_tick periods in the stop bit.
REQ-003 The module SHALL have parameter FIFO_W, default 4, FIFO address width, giving a depth of 2^FIFO_W words.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The module SHALL have port s_tick, input, 1 bit, a one-cycle baud-oversampling strobe at 16x the baud rate.
REQ-007 The module SHALL have port wr, input, 1 bit, a write strobe that pushes w_data into the FIFO.
REQ-008 The module SHALL have port w_data, input, DBIT bits, the byte to transmit.
REQ-009 The module SHALL have port full, output, 1 bit, high when the FIFO holds 2^FIFO_W words.
REQ-010 The module SHALL have port empty, output, 1 bit, high when the FIFO holds 0 words.
REQ-011 The module SHALL have port tx, output, 1 bit, the registered serial line, idle high.
REQ-012 The module SHALL have port tx_busy, output, 1 bit, high whenever the serializer is not in IDLE.
REQ-013 The module SHALL have port tx_done_tick, output, 1 bit, a one-cycle pulse at the end of each stop bit.

Function
REQ-014 The FIFO SHALL be circular, with write and read pointers of FIFO_W bits that wrap modulo 2^FIFO_W.
REQ-015 full and empty SHALL be registered flags, updated on the same edge as the pointers.
REQ-016 A wr while full SHALL be ignored, including when a pop occurs in the same cycle; data and pointers stay unchanged.
REQ-017 A simultaneous wr and pop with the FIFO neither full nor empty SHALL advance both pointers and leave the flags unchanged.
REQ-018 A wr while empty SHALL store the word and clear empty on that edge; the serializer never pops while empty is high.
REQ-019 The serializer SHALL use the states IDLE, START, DATA and STOP, with a 4-bit tick counter s, a bit counter n of ceil(log2(DBIT)) bits, and a DBIT-bit shift register b.
REQ-020 In IDLE with empty low, on the next edge: b loads the FIFO head, the FIFO pops, s resets to 0, state goes to START, and tx goes to 0.
REQ-021 In START, tx SHALL be 0; on s_tick with s==15, s resets to 0, n resets to 0, and state goes to DATA; on any other s_tick, s increments.
REQ-022 In DATA, tx SHALL equal b[0]; on s_tick with s==15, b shifts right, s resets to 0, and n increments; when n==DBIT-1, state goes to STOP and tx goes to 1.
REQ-023 In STOP, tx SHALL be 1; on s_tick with s==SB_TICK-1, tx_done_tick pulses high for exactly one cycle and state returns to IDLE.
REQ-024 Counters SHALL advance only on s_tick cycles; cycles without s_tick hold all serializer state.
REQ-025 Bits SHALL be transmitted LSB first, with exactly one start bit, DBIT data bits and one stop bit of SB_TICK ticks.
REQ-026 Latency: wr into an empty FIFO with the serializer IDLE SHALL drive tx low on the second rising edge after the wr edge.
REQ-027 Back-to-back bytes: after STOP completes with the FIFO non-empty, IDLE SHALL last exactly one cycle before the next START.
REQ-028 FIFO writes SHALL be accepted during any serializer state and SHALL NOT disturb a frame in progress.

Reset
REQ-029 On reset, the FIFO pointers SHALL go to 0, empty to 1, full to 0, state to IDLE, s, n and b to 0, tx to 1, tx_busy to 0 and tx_done_tick to 0.
REQ-030 A reset asserted mid-frame SHALL abort the frame, returning tx to 1 on the next edge and discarding all FIFO contents.
REQ-031 wr and s_tick SHALL be ignored in any cycle where reset is high.

Verification
REQ-032 Reset, then with s_tick every cycle write 0xA5 -> tx frame is 0, 1,0,1,0,0,1,0,1, 1, each bit held 16 cycles; one tx_done_tick; empty stays 1 afterwards.
REQ-033 With s_tick stalled, write 16 bytes 0x00..0x0F -> full=1 after the 16th write; a 17th write 0xFF is dropped; the received sequence is 0x00..0x0F in order.
REQ-034 Two bytes 0x55 then 0x0F written on consecutive cycles -> two frames separated by exactly one idle cycle; two tx_done_tick pulses.
REQ-035 s_tick every 326 cycles, write 0x3C -> the frame length is 160*326 clocks plus alignment; tx_busy is high throughout.
REQ-036 Reset asserted during DATA bit 3 -> tx=1, tx_busy=0, empty=1 on the next edge; no tx_done_tick.
REQ-037 Simultaneous wr and pop while the FIFO holds 1 word -> the count stays 1, empty stays 0, and the new word is transmitted next.
